// File: rtl/lsu_align_pkg.sv
// Shared encodings and helpers for the load/store alignment unit:
// access-size and FSM state encodings, byte count per size, load extension.
package lsu_align_pkg;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'b00,
    LSU_SIZE_H = 2'b01,
    LSU_SIZE_W = 2'b10,
    LSU_SIZE_D = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    LSU_S_IDLE  = 3'd0,
    LSU_S_BEAT0 = 3'd1,
    LSU_S_WAIT0 = 3'd2,
    LSU_S_BEAT1 = 3'd3,
    LSU_S_WAIT1 = 3'd4,
    LSU_S_RESP  = 3'd5
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input lsu_size_e size);
    logic [3:0] n;
    case (size)
      LSU_SIZE_B: n = 4'd1;
      LSU_SIZE_H: n = 4'd2;
      LSU_SIZE_W: n = 4'd4;
      LSU_SIZE_D: n = 4'd8;
      default:    n = 4'd1;
    endcase
    return n;
  endfunction

  // Keep the low bytes of a right-justified load and extend from their top bit.
  function automatic logic [63:0] load_extend(input logic [63:0] data, input lsu_size_e size,
                                              input logic is_unsigned);
    logic [63:0] keep;
    logic        sign;
    case (size)
      LSU_SIZE_B: begin keep = 64'h0000_0000_0000_00FF; sign = data[7];  end
      LSU_SIZE_H: begin keep = 64'h0000_0000_0000_FFFF; sign = data[15]; end
      LSU_SIZE_W: begin keep = 64'h0000_0000_FFFF_FFFF; sign = data[31]; end
      LSU_SIZE_D: begin keep = 64'hFFFF_FFFF_FFFF_FFFF; sign = data[63]; end
      default:    begin keep = 64'h0000_0000_0000_00FF; sign = data[7];  end
    endcase
    if (is_unsigned || !sign) begin
      return data & keep;
    end else begin
      return (data & keep) | ~keep;
    end
  endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Request, data-memory and response signals of the alignment unit.
// master = core/memory side, slave = the alignment unit.
interface lsu_align_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [XLEN-1:0]   req_wdata;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready,
    input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready,
    output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_lane_mask.sv
// Byte-lane geometry of one bus beat: enables for (off, size, beat) and the
// bit shift that moves data between right-justified form and its lanes.
module lsu_lane_mask
  import lsu_align_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [$clog2(NB)-1:0] off,
  input  lsu_size_e             size,
  input  logic                  beat,
  output logic [NB-1:0]         be,
  output logic [$clog2(NB)+3:0] shamt
);
  localparam int OFF_W = $clog2(NB);

  logic [2*NB-1:0] one_s;
  logic [2*NB-1:0] span_s;
  logic [2*NB-1:0] placed_s;
  logic [OFF_W:0]  lanes_s;

  // Place the access span across two lines; beat 0 owns the low line, beat 1 the spill-over.
  always_comb begin
    one_s    = {{(2*NB-1){1'b0}}, 1'b1};
    span_s   = (one_s << size_bytes(size)) - one_s;
    placed_s = span_s << off;
    if (beat) begin
      be      = placed_s[2*NB-1:NB];
      lanes_s = (OFF_W+1)'(NB) - {1'b0, off};
    end else begin
      be      = placed_s[NB-1:0];
      lanes_s = {1'b0, off};
    end
    shamt = {lanes_s, 3'b000};
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: store lane placement, load merge and extension, one access in flight.
// Define LSU_MISALIGN_SPLIT_EN to split line-crossing accesses into two beats; otherwise they fault.
module lsu_align
  import lsu_align_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input logic        clk,
  input logic        reset,
  lsu_align_if.slave bus
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int SH_W  = OFF_W + 4;

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  lsu_size_e         size_q, size_d;
  logic [OFF_W-1:0]  off_q, off_d;

  logic              req_ready_q, req_ready_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [OFF_W-1:0]  off_new_s;
  lsu_size_e         size_new_s;
  logic              split_new_s;
  logic              err_new_s;
  logic [OFF_W-1:0]  lm0_off_s;
  lsu_size_e         lm0_size_s;
  logic [NB-1:0]     be0_s;
  logic [SH_W-1:0]   sh0_s;
  logic [XLEN-1:0]   load_s;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   merge_q, merge_d;
  logic [NB-1:0]     be1_s;
  logic [SH_W-1:0]   sh1_s;
  logic [ADDR_W-1:0] b1_addr_s;
`endif

  assign off_new_s   = bus.req_addr[OFF_W-1:0];
  assign size_new_s  = lsu_size_e'(bus.req_size);
  assign split_new_s = (5'(off_new_s) + 5'(size_bytes(size_new_s))) > 5'(NB);
`ifdef LSU_MISALIGN_SPLIT_EN
  assign err_new_s   = (XLEN < 64) && (size_new_s == LSU_SIZE_D);
`else
  assign err_new_s   = ((XLEN < 64) && (size_new_s == LSU_SIZE_D)) || split_new_s;
`endif

  // Beat-0 geometry follows the incoming request in IDLE and the latched one afterwards.
  assign lm0_off_s  = (state_q == LSU_S_IDLE) ? off_new_s : off_q;
  assign lm0_size_s = (state_q == LSU_S_IDLE) ? size_new_s : size_q;

  lsu_lane_mask #(.NB(NB)) u_lm0 (
    .off   (lm0_off_s),
    .size  (lm0_size_s),
    .beat  (1'b0),
    .be    (be0_s),
    .shamt (sh0_s)
  );

`ifdef LSU_MISALIGN_SPLIT_EN
  lsu_lane_mask #(.NB(NB)) u_lm1 (
    .off   (off_q),
    .size  (size_q),
    .beat  (1'b1),
    .be    (be1_s),
    .shamt (sh1_s)
  );

  // mem_addr_q still holds the beat-0 line address while in BEAT0/WAIT0.
  assign b1_addr_s = mem_addr_q + ADDR_W'(NB);
`endif

  // Next state, latched request, and the next values of every registered output.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    uns_d       = uns_q;
    size_d      = size_q;
    off_d       = off_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = {XLEN{1'b0}};
    load_s      = {XLEN{1'b0}};
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d     = split_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
`endif
    case (state_q)
      LSU_S_IDLE: begin
        if (bus.req_valid) begin
          we_d   = bus.req_we;
          uns_d  = bus.req_unsigned;
          size_d = size_new_s;
          off_d  = off_new_s;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_d = split_new_s;
          wdata_d = bus.req_wdata;
`endif
          if (err_new_s) begin
            state_d   = LSU_S_RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d     = LSU_S_BEAT0;
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_be_d    = be0_s;
            mem_wdata_d = bus.req_wdata << sh0_s;
          end
        end else begin
          state_d = LSU_S_IDLE;
        end
      end
      LSU_S_BEAT0: begin
        if (bus.mem_ready) begin
          if (!we_q) begin
            state_d = LSU_S_WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
          end else if (split_q) begin
            state_d     = LSU_S_BEAT1;
            mem_addr_d  = b1_addr_s;
            mem_be_d    = be1_s;
            mem_wdata_d = wdata_q >> sh1_s;
`endif
          end else begin
            state_d = LSU_S_RESP;
          end
        end else begin
          state_d = LSU_S_BEAT0;
        end
      end
      LSU_S_WAIT0: begin
        if (bus.mem_rvalid) begin
          load_s = bus.mem_rdata >> sh0_s;
`ifdef LSU_MISALIGN_SPLIT_EN
          merge_d = load_s;
          if (split_q) begin
            state_d     = LSU_S_BEAT1;
            mem_addr_d  = b1_addr_s;
            mem_be_d    = be1_s;
            mem_wdata_d = wdata_q >> sh1_s;
          end else begin
            state_d     = LSU_S_RESP;
            rsp_rdata_d = XLEN'(load_extend(64'(load_s), size_q, uns_q));
          end
`else
          state_d     = LSU_S_RESP;
          rsp_rdata_d = XLEN'(load_extend(64'(load_s), size_q, uns_q));
`endif
        end else begin
          state_d = LSU_S_WAIT0;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      LSU_S_BEAT1: begin
        if (bus.mem_ready) begin
          state_d = we_q ? LSU_S_RESP : LSU_S_WAIT1;
        end else begin
          state_d = LSU_S_BEAT1;
        end
      end
      LSU_S_WAIT1: begin
        if (bus.mem_rvalid) begin
          load_s      = merge_q | (bus.mem_rdata << sh1_s);
          merge_d     = load_s;
          state_d     = LSU_S_RESP;
          rsp_rdata_d = XLEN'(load_extend(64'(load_s), size_q, uns_q));
        end else begin
          state_d = LSU_S_WAIT1;
        end
      end
`endif
      LSU_S_RESP: begin
        state_d = LSU_S_IDLE;
      end
      default: begin
        state_d = LSU_S_IDLE;
      end
    endcase
    req_ready_d = (state_d == LSU_S_IDLE);
    mem_valid_d = (state_d == LSU_S_BEAT0) || (state_d == LSU_S_BEAT1);
    rsp_valid_d = (state_d == LSU_S_RESP);
  end

  // State, latched request and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LSU_S_IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= LSU_SIZE_B;
      off_q       <= {OFF_W{1'b0}};
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_be_q    <= {NB{1'b0}};
      mem_wdata_q <= {XLEN{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {XLEN{1'b0}};
      rsp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      wdata_q     <= {XLEN{1'b0}};
      merge_q     <= {XLEN{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      off_q       <= off_d;
      req_ready_q <= req_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q     <= split_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align at XLEN=32; line-crossing expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_align;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  lsu_align_if #(.XLEN(32), .ADDR_W(32)) bus ();
  lsu_align #(.XLEN(32), .ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
  endtask

  // Single-beat load with mem_ready=1 and rvalid one cycle after the beat.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [3:0] e_be, input logic [31:0] e_res);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    drive_req(1'b0, addr, size, uns, 32'h0000_0000);
    tick();
    bus.req_valid = 1'b0;
    chk({tag, "_mem_valid"}, 64'(bus.mem_valid), 64'd1);
    chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(e_addr));
    chk({tag, "_mem_be"}, 64'(bus.mem_be), 64'(e_be));
    tick();
    chk({tag, "_wait_valid"}, 64'(bus.mem_valid), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    tick();
    bus.mem_rvalid = 1'b0;
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(e_res));
    tick();
    chk({tag, "_rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(bus.req_ready), 64'd1);
  endtask

  // Faulting access: response the cycle after acceptance, no bus beat.
  task automatic do_err(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata);
    drive_req(we, addr, size, 1'b0, wdata);
    tick();
    bus.req_valid = 1'b0;
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd1);
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    chk({tag, "_no_beat"}, 64'(bus.mem_valid), 64'd0);
    tick();
    chk({tag, "_no_beat2"}, 64'(bus.mem_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h0000_0000;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h0000_0000;
    bus.mem_ready    = 1'b1;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = 32'h0000_0000;
    tick();
    tick();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_be", 64'(bus.mem_be), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    reset = 1'b0;
    tick();

    do_load("lw",  32'h8000_0004, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h8000_0004, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb",  32'h8000_0003, 2'b00, 1'b0, 32'h8012_3456, 32'h8000_0000, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 32'h8000_0003, 2'b00, 1'b1, 32'h8012_3456, 32'h8000_0000, 4'b1000, 32'h0000_0080);
    do_load("lh",  32'h8000_0006, 2'b01, 1'b0, 32'h8001_1234, 32'h8000_0004, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", 32'h8000_0004, 2'b01, 1'b1, 32'h8001_F00D, 32'h8000_0004, 4'b0011, 32'h0000_F00D);

    // Halfword store held off by mem_ready=0 for three cycles.
    bus.mem_ready = 1'b0;
    drive_req(1'b1, 32'h8000_0002, 2'b01, 1'b0, 32'h0000_ABCD);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_stall_valid", 64'(bus.mem_valid), 64'd1);
      chk("sh_stall_we", 64'(bus.mem_we), 64'd1);
      chk("sh_stall_addr", 64'(bus.mem_addr), 64'h8000_0000);
      chk("sh_stall_be", 64'(bus.mem_be), 64'b1100);
      chk("sh_stall_wdata", 64'(bus.mem_wdata), 64'hABCD_0000);
      chk("sh_stall_rsp", 64'(bus.rsp_valid), 64'd0);
      tick();
    end
    chk("sh_beat_valid", 64'(bus.mem_valid), 64'd1);
    chk("sh_beat_wdata", 64'(bus.mem_wdata), 64'hABCD_0000);
    bus.mem_ready = 1'b1;
    tick();
    chk("sh_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("sh_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("sh_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("sh_beat_done", 64'(bus.mem_valid), 64'd0);
    tick();
    chk("sh_ready_back", 64'(bus.req_ready), 64'd1);

    // Aligned store timing: response two cycles after acceptance.
    drive_req(1'b1, 32'h8000_0010, 2'b10, 1'b0, 32'h1234_5678);
    tick();
    bus.req_valid = 1'b0;
    chk("sw_beat_be", 64'(bus.mem_be), 64'b1111);
    chk("sw_beat_wdata", 64'(bus.mem_wdata), 64'h1234_5678);
    chk("sw_no_rsp_yet", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("sw_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    tick();

    do_err("sd_illegal", 1'b1, 32'h8000_0000, 2'b11, 32'h1234_5678);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Line-crossing word load split over two beats.
    drive_req(1'b0, 32'h8000_0003, 2'b10, 1'b0, 32'h0000_0000);
    tick();
    bus.req_valid = 1'b0;
    chk("lw_split_b0_valid", 64'(bus.mem_valid), 64'd1);
    chk("lw_split_b0_addr", 64'(bus.mem_addr), 64'h8000_0000);
    chk("lw_split_b0_be", 64'(bus.mem_be), 64'b1000);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1100_0000;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("lw_split_b1_valid", 64'(bus.mem_valid), 64'd1);
    chk("lw_split_b1_addr", 64'(bus.mem_addr), 64'h8000_0004);
    chk("lw_split_b1_be", 64'(bus.mem_be), 64'b0111);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0044_3322;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("lw_split_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("lw_split_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("lw_split_rsp_rdata", 64'(bus.rsp_rdata), 64'h4433_2211);
    tick();

    // Line-crossing word store wrapping the address space.
    drive_req(1'b1, 32'hFFFF_FFFE, 2'b10, 1'b0, 32'hAABB_CCDD);
    tick();
    bus.req_valid = 1'b0;
    chk("sw_split_b0_addr", 64'(bus.mem_addr), 64'hFFFF_FFFC);
    chk("sw_split_b0_be", 64'(bus.mem_be), 64'b1100);
    chk("sw_split_b0_wdata", 64'(bus.mem_wdata), 64'hCCDD_0000);
    tick();
    chk("sw_split_b1_valid", 64'(bus.mem_valid), 64'd1);
    chk("sw_split_b1_addr", 64'(bus.mem_addr), 64'h0000_0000);
    chk("sw_split_b1_be", 64'(bus.mem_be), 64'b0011);
    chk("sw_split_b1_wdata", 64'(bus.mem_wdata), 64'h0000_AABB);
    tick();
    chk("sw_split_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("sw_split_rsp_err", 64'(bus.rsp_err), 64'd0);
    tick();
`else
    do_err("lw_split", 1'b0, 32'h8000_0003, 2'b10, 32'h0000_0000);
    do_err("sw_split", 1'b1, 32'hFFFF_FFFE, 2'b10, 32'hAABB_CCDD);
`endif

    // Reset while waiting for load data; the late rvalid must be ignored.
    drive_req(1'b0, 32'h8000_0008, 2'b10, 1'b0, 32'h0000_0000);
    tick();
    bus.req_valid = 1'b0;
    chk("rst_mid_beat", 64'(bus.mem_valid), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mid_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_mid_rsp", 64'(bus.rsp_valid), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55AA_55AA;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("rst_late_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("rst_late_ready", 64'(bus.req_ready), 64'd1);
    tick();
    chk("rst_late_rsp2", 64'(bus.rsp_valid), 64'd0);
    do_load("lw_after_rst", 32'h8000_000C, 2'b10, 1'b0, 32'h0BAD_F00D, 32'h8000_000C, 4'b1111,
            32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
